board_controller: RTL and testbench



---
 rtl/tictactoe_pkg.sv | 12 +
 rtl/board_controller_if.sv | 22 ++
 rtl/board_controller_win_detect.sv | 16 +
 rtl/board_controller.sv | 80 ++++++++
 tb/tb_board_controller.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/tictactoe_pkg.sv
// tictactoe_pkg: shared cell/result encodings, board-controller state enum and address constants.
package tictactoe_pkg;
   localparam logic [1:0] EMPTY = 2'b00;
   localparam logic [1:0] P1    = 2'b11;
   localparam logic [1:0] P2    = 2'b10;
   localparam logic [1:0] NOWIN = 2'b00;
   localparam logic [1:0] TIE   = 2'b01;
   localparam logic [1:0] P1WIN = 2'b11;
   localparam logic [1:0] P2WIN = 2'b10;
   localparam logic [3:0] BAD_ADDR = 4'b1111;
   typedef enum logic [1:0] {P1_TURN, P2_TURN, CHECK, DONE} bc_state_e;
endpackage

// File: rtl/board_controller_if.sv
// board_controller_if: move-request inputs and board/status outputs of the board controller.
//   master: move sources (playerWrite/playerAddr, aiAddr/aiWriteN), observes status.
//   slave : board controller, drives gBoard, cellState, result, moveCount, illegalMove.
interface board_controller_if;
   logic        playerWrite;
   logic [3:0]  playerAddr;
   logic [3:0]  aiAddr;
   logic        aiWriteN;
   logic [17:0] gBoard;
   logic [1:0]  cellState;
   logic [1:0]  result;
   logic [3:0]  moveCount;
   logic        illegalMove;
   modport master (
      output playerWrite, playerAddr, aiAddr, aiWriteN,
      input  gBoard, cellState, result, moveCount, illegalMove
   );
   modport slave (
      input  playerWrite, playerAddr, aiAddr, aiWriteN,
      output gBoard, cellState, result, moveCount, illegalMove
   );
endinterface

// File: rtl/board_controller_win_detect.sv
// win_detect: combinational three-in-a-row detector for one player code.
//   gBoard_i: 18-bit board, cell i at [2i+1:2i], row-major.
//   code_i  : player code to test.   win_o: any row, column or diagonal fully owned.
module win_detect (
   input  logic [17:0] gBoard_i,
   input  logic [1:0]  code_i,
   output logic        win_o
);
   logic [8:0] m;
   for (genvar i = 0; i < 9; i++) begin : g_cell
      assign m[i] = gBoard_i[2*i +: 2] == code_i;
   end
   assign win_o = (&m[2:0]) | (&m[5:3]) | (&m[8:6]) |
                  (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
                  (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
endmodule

// File: rtl/board_controller.sv
// board_controller: validates and writes tic-tac-toe moves, sequences turns, publishes win/tie.
//   ph1/ph2: two-phase clock, state advances on ph1 rising.   reset: sync, active-high.
//   bus    : board_controller_if.slave (move requests in, board and game status out).
//   BOARD_CTRL_AI_FIRST_EN: when defined the AI (player 2) moves first after reset.
module board_controller
   import tictactoe_pkg::*;
(
   input  logic ph1,
   input  logic ph2,
   input  logic reset,
   board_controller_if.slave bus
);
`ifdef BOARD_CTRL_AI_FIRST_EN
   localparam bc_state_e RST_STATE = P2_TURN;
`else
   localparam bc_state_e RST_STATE = P1_TURN;
`endif
   bc_state_e   state_q, state_d;
   logic [1:0]  mover_q, mover_d, result_q, result_d, turn;
   logic [17:0] board_q, board_d;
   logic [3:0]  count_q, count_d, addr;
   logic        ill_q, ill_d, req, free, wr, win, unused_ph2;
   logic [31:0] ext;

   assign unused_ph2 = ph2;
   // zero-padded board so out-of-range addresses index safely; they are rejected anyway
   assign ext  = {14'd0, board_q};
   assign turn = state_q == P1_TURN ? P1 : P2;
   assign addr = state_q == P1_TURN ? bus.playerAddr : bus.aiAddr;
   assign req  = state_q == P1_TURN ? bus.playerWrite : state_q == P2_TURN && !bus.aiWriteN;
   assign free = addr <= 4'd8 && ext[{addr, 1'b0} +: 2] == EMPTY;
   assign wr   = req && free;

   win_detect u_win (.gBoard_i(board_q), .code_i(mover_q), .win_o(win));

   always_comb begin
      state_d  = state_q;
      mover_d  = mover_q;
      board_d  = board_q;
      count_d  = count_q;
      result_d = result_q;
      ill_d    = req && !free;
      if (wr) begin
         board_d[{addr, 1'b0} +: 2] = turn;
         count_d = count_q == 4'd9 ? count_q : count_q + 4'd1;
         mover_d = turn;
         state_d = CHECK;
      end
      // a win on the ninth move takes precedence over the tie
      if (state_q == CHECK) begin
         result_d = win ? (mover_q == P1 ? P1WIN : P2WIN) : count_q == 4'd9 ? TIE : NOWIN;
         state_d  = win || count_q == 4'd9 ? DONE : mover_q == P1 ? P2_TURN : P1_TURN;
      end
   end

   always_ff @(posedge ph1) begin
      if (reset) begin
         state_q  <= RST_STATE;
         mover_q  <= P1;
         board_q  <= '0;
         count_q  <= '0;
         result_q <= NOWIN;
         ill_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mover_q  <= mover_d;
         board_q  <= board_d;
         count_q  <= count_d;
         result_q <= result_d;
         ill_q    <= ill_d;
      end
   end

   assign bus.gBoard      = board_q;
   assign bus.cellState   = state_q == P1_TURN ? P1 : state_q == P2_TURN ? P2 :
                            state_q == CHECK ? mover_q : EMPTY;
   assign bus.result      = result_q;
   assign bus.moveCount   = count_q;
   assign bus.illegalMove = ill_q;
endmodule

// File: tb/tb_board_controller.sv
// tb_board_controller: scoreboard bench for board_controller driven through board_controller_if.
module tb_board_controller;
   import tictactoe_pkg::*;
`ifdef BOARD_CTRL_AI_FIRST_EN
   localparam logic [1:0] RST_CS = P2;
`else
   localparam logic [1:0] RST_CS = P1;
`endif
   logic ph1, ph2, reset;
   board_controller_if bus();
   board_controller dut (.ph1(ph1), .ph2(ph2), .reset(reset), .bus(bus));

   typedef struct {
      string       tag;
      logic [17:0] b;
      logic [1:0]  cs;
      logic [1:0]  res;
      logic [3:0]  cnt;
      logic        ill;
   } exp_t;
   exp_t sb[$];
   int vectors = 0, miscompares = 0;
   logic [17:0] sh_b;
   logic [1:0]  sh_cs, sh_res;
   logic [3:0]  sh_cnt;

   initial begin
      ph1 = 0;
      ph2 = 0;
      forever begin
         #1 ph1 = 1;
         #4 ph1 = 0;
         #1 ph2 = 1;
         #3 ph2 = 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic push(input string tag, input logic ill);
      exp_t e;
      e.tag = tag; e.b = sh_b; e.cs = sh_cs; e.res = sh_res; e.cnt = sh_cnt; e.ill = ill;
      sb.push_back(e);
   endtask

   task automatic tick();
      exp_t e;
      @(posedge ph1);
      #1;
      if (sb.size() == 0) begin
         check("sb_underflow", 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      check({e.tag, ".board"}, 32'(bus.gBoard), 32'(e.b));
      check({e.tag, ".cs"}, 32'(bus.cellState), 32'(e.cs));
      check({e.tag, ".res"}, 32'(bus.result), 32'(e.res));
      check({e.tag, ".cnt"}, 32'(bus.moveCount), 32'(e.cnt));
      check({e.tag, ".ill"}, 32'(bus.illegalMove), 32'(e.ill));
   endtask

   task automatic idle_inputs();
      bus.playerWrite = 0;
      bus.aiWriteN = 1;
   endtask

   task automatic do_reset(input string tag);
      reset = 1;
      idle_inputs();
      sh_b = '0; sh_cnt = '0; sh_cs = RST_CS; sh_res = NOWIN;
      push(tag, 1'b0);
      tick();
      reset = 0;
   endtask

   // one request from human (or AI), held for hold cycles; cs2/res2 are the expected
   // status two cycles after an accepted move; both also drives the other source with oa
   task automatic move(input string tag, input bit human, input logic [3:0] a,
                       input logic [1:0] cs2, input logic [1:0] res2,
                       input int hold = 1, input bit both = 0, input logic [3:0] oa = 4'd0);
      logic [1:0] code;
      bit on_turn, legal;
      int n;
      code = human ? P1 : P2;
      on_turn = sh_cs == code;
      legal = on_turn && a <= 4'd8 && sh_b[2*a+1] == 1'b0;
      n = (legal && hold < 2) ? 2 : hold;
      if (legal) begin
         sh_b[2*a +: 2] = code;
         sh_cnt++;
         sh_cs = code;
         push({tag, "@chk"}, 1'b0);
         sh_cs = cs2;
         sh_res = res2;
         for (int i = 1; i < n; i++) push(tag, 1'b0);
      end else begin
         for (int i = 0; i < n; i++) push(tag, on_turn && i < hold);
      end
      if (human || both) begin
         bus.playerWrite = 1;
         bus.playerAddr = human ? a : oa;
      end
      if (!human || both) begin
         bus.aiWriteN = 0;
         bus.aiAddr = human ? oa : a;
      end
      for (int i = 0; i < n; i++) begin
         if (i == hold) idle_inputs();
         tick();
      end
      idle_inputs();
   endtask

   task automatic idle(input string tag);
      push(tag, 1'b0);
      tick();
   endtask

   initial begin
      reset = 1;
      bus.playerAddr = 0;
      bus.aiAddr = BAD_ADDR;
      idle_inputs();
      do_reset("rst0");
      move("h4", 1, 4, P2, NOWIN);
      move("ai0_hold", 0, 0, P1, NOWIN, 3);
      move("occ4", 1, 4, sh_cs, sh_res);
      move("addr9", 1, 9, sh_cs, sh_res);
      move("addr15", 1, BAD_ADDR, sh_cs, sh_res);
      move("off_ai", 0, 5, sh_cs, sh_res);
      move("both", 1, 1, P2, NOWIN, 1, 1, 2);
      move("ai2", 0, 2, P1, NOWIN);
      // human wins on row 0
      do_reset("rst_win");
      move("w_h0", 1, 0, P2, NOWIN);
      move("w_a3", 0, 3, P1, NOWIN);
      move("w_h1", 1, 1, P2, NOWIN);
      move("w_a4", 0, 4, P1, NOWIN);
      move("w_h2", 1, 2, EMPTY, P1WIN);
      move("late_h", 1, 5, sh_cs, sh_res);
      move("late_ai", 0, 5, sh_cs, sh_res);
      idle("done_idle");
      // full board, no line
      do_reset("rst_tie");
      move("t_h0", 1, 0, P2, NOWIN);
      move("t_a1", 0, 1, P1, NOWIN);
      move("t_h2", 1, 2, P2, NOWIN);
      move("t_a4", 0, 4, P1, NOWIN);
      move("t_h3", 1, 3, P2, NOWIN);
      move("t_a5", 0, 5, P1, NOWIN);
      move("t_h7", 1, 7, P2, NOWIN);
      move("t_a6", 0, 6, P1, NOWIN);
      move("t_h8", 1, 8, EMPTY, TIE);
      move("t_late", 1, 4, sh_cs, sh_res);
      // win on the ninth move reports the winner
      do_reset("rst_w9");
      move("n_h2", 1, 2, P2, NOWIN);
      move("n_a1", 0, 1, P1, NOWIN);
      move("n_h7", 1, 7, P2, NOWIN);
      move("n_a4", 0, 4, P1, NOWIN);
      move("n_h0", 1, 0, P2, NOWIN);
      move("n_a5", 0, 5, P1, NOWIN);
      move("n_h3", 1, 3, P2, NOWIN);
      move("n_a8", 0, 8, P1, NOWIN);
      move("n_h6", 1, 6, EMPTY, P1WIN);
      // reset while CHECK holds a pending win
      do_reset("rst_chk");
      move("c_h0", 1, 0, P2, NOWIN);
      move("c_a3", 0, 3, P1, NOWIN);
      move("c_h1", 1, 1, P2, NOWIN);
      move("c_a4", 0, 4, P1, NOWIN);
      bus.playerWrite = 1;
      bus.playerAddr = 2;
      sh_b[5:4] = P1;
      sh_cnt++;
      push("c_h2@chk", 1'b0);
      tick();
      do_reset("rst_in_chk");
      idle("after_rst");
      move("post_h8", 1, 8, P2, NOWIN);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
